// File: rtl/truth_table_scanner_pkg.sv
// Shared types for truth-table scanners: FSM state encoding and vector-count helper.
// Latency: none (types and constant functions only).
// Backpressure: none.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of distinct input vectors for an n_in-input block.
    function automatic int num_vec(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/truth_table_scanner_hold_timer.sv
// Hold timer: SETTLE-cycle down-counter that paces how long each vector is applied.
// Latency: expire is high SETTLE cycles after load (same cycle as load edge when SETTLE=0).
// Backpressure: none; load restarts the count unconditionally.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset (counter cleared, expire high)
//   load   - reload the counter with SETTLE at the next edge
//   expire - counter has reached zero; the current hold period ends this cycle
module hold_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);

    // One bit minimum so SETTLE=0 still yields a legal (constant-zero) counter.
    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(SETTLE);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Truth-table scanner: walks all 2**N_IN input vectors, samples f_in and grades it against EXPECTED.
// Latency: done pulses in the cycle after edge k + 2**N_IN*(SETTLE+1), where k is the start edge.
// Backpressure: none; start is ignored while scanning, abort returns to IDLE at the next edge.
//
// Ports:
//   clk, rst         - clock and synchronous active-high reset
//   start, abort     - begin a scan (IDLE/DONE only); abandon any activity (wins over start)
//   vec_out, f_in    - vector driven to the block under test and its sampled response
//   busy, done       - scanning flag; one-cycle pulse on entry to DONE
//   table_out, pass  - observed truth table; table matched EXPECTED (valid in DONE)
//   err_count        - mismatching vectors so far
//   first_err_idx/_valid - lowest mismatching vector and whether one was seen
module truth_table_scanner
    import scan_pkg::*;
#(
    parameter int                  N_IN     = 4,
    parameter int                  SETTLE   = 1,
    parameter logic [2**N_IN-1:0]  EXPECTED = 16'hF830
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic [N_IN-1:0]     vec_out,
    input  logic                f_in,
    output logic                busy,
    output logic                done,
    output logic [2**N_IN-1:0]  table_out,
    output logic                pass,
    output logic [N_IN:0]       err_count,
    output logic [N_IN-1:0]     first_err_idx,
    output logic                first_err_valid
);

    localparam int              NUM_VEC  = num_vec(N_IN);
    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NUM_VEC - 1);

    state_t              state;
    logic                expire;
    logic                start_acc;
    logic                timer_load;
    logic                mismatch;
    logic [NUM_VEC-1:0]  table_nxt;

    // A scan begins with a fresh hold period, and each sample starts the next one.
    assign start_acc  = (state != SCAN) && start && !abort;
    assign timer_load = start_acc || ((state == SCAN) && expire);

    hold_timer #(
        .SETTLE (SETTLE)
    ) u_hold (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .expire (expire)
    );

    assign mismatch = (f_in != EXPECTED[vec_out]);

    // Table including the sample taken this cycle, so pass can be graded on the
    // same edge that records the last vector.
    always_comb begin
        table_nxt          = table_out;
        table_nxt[vec_out] = f_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            vec_out         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            table_out       <= '0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_idx   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // Partial results stay visible for debug, but are never graded.
                state   <= IDLE;
                vec_out <= '0;
                busy    <= 1'b0;
                pass    <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            state           <= SCAN;
                            busy            <= 1'b1;
                            vec_out         <= '0;
                            table_out       <= '0;
                            pass            <= 1'b0;
                            err_count       <= '0;
                            first_err_idx   <= '0;
                            first_err_valid <= 1'b0;
                        end
                    end
                    SCAN: begin
                        if (expire) begin
                            table_out <= table_nxt;
                            if (mismatch) begin
                                err_count <= err_count + 1'b1;
                                if (!first_err_valid) begin
                                    first_err_idx   <= vec_out;
                                    first_err_valid <= 1'b1;
                                end
                            end
                            if (vec_out == LAST_VEC) begin
                                // vec_out parks on the last vector until the next start.
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                pass  <= (table_nxt == EXPECTED);
                            end else begin
                                vec_out <= vec_out + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: two instances (SETTLE=1 and SETTLE=0) share start/abort/rst
// and each sees a block under test modelled as a 16-entry lookup table indexed by its vec_out.
// Expected results come from a vector-level model: popcount / lowest-set-bit over table XOR EXPECTED.
module tb_truth_table_scanner;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] tab;

    logic [3:0]  vec_out1, vec_out0;
    logic        f_in1, f_in0;
    logic        busy1, busy0, done1, done0, pass1, pass0;
    logic [15:0] table_out1, table_out0;
    logic [4:0]  err_count1, err_count0;
    logic [3:0]  first_err_idx1, first_err_idx0;
    logic        first_err_valid1, first_err_valid0;

    logic [15:0] exp_tab;

    int n_vec;
    int n_miss;

    assign f_in1 = tab[vec_out1];
    assign f_in0 = tab[vec_out0];

    truth_table_scanner #(.N_IN(4), .SETTLE(1), .EXPECTED(16'hF830)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .vec_out(vec_out1), .f_in(f_in1), .busy(busy1), .done(done1),
        .table_out(table_out1), .pass(pass1), .err_count(err_count1),
        .first_err_idx(first_err_idx1), .first_err_valid(first_err_valid1)
    );

    truth_table_scanner #(.N_IN(4), .SETTLE(0), .EXPECTED(16'hF830)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .vec_out(vec_out0), .f_in(f_in0), .busy(busy0), .done(done0),
        .table_out(table_out0), .pass(pass0), .err_count(err_count0),
        .first_err_idx(first_err_idx0), .first_err_valid(first_err_valid0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // F = A(B + CD) + BC', A = bit 3 ... D = bit 0; drop_bc removes the BC' term.
    function automatic logic [15:0] formula(input bit drop_bc);
        logic [15:0] t;
        logic [3:0]  v;
        t = '0;
        for (int i = 0; i < 16; i++) begin
            v = i[3:0];
            t[i] = (v[3] & (v[2] | (v[1] & v[0]))) | (!drop_bc & v[2] & ~v[1]);
        end
        return t;
    endfunction

    // Model results after the first n vectors of table t have been sampled.
    function automatic int m_err(input logic [15:0] t, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (t[i] != exp_tab[i]) c++;
        return c;
    endfunction

    function automatic int m_first(input logic [15:0] t, input int n);
        for (int i = 0; i < n; i++) if (t[i] != exp_tab[i]) return i;
        return 0;
    endfunction

    function automatic logic [15:0] m_table(input logic [15:0] t, input int n);
        logic [15:0] r = '0;
        for (int i = 0; i < n; i++) r[i] = t[i];
        return r;
    endfunction

    task automatic check_results(input string tag, input logic [15:0] t, input int n1, input int n0,
                                 input bit graded);
        chk({tag, ".table1"}, table_out1, m_table(t, n1));
        chk({tag, ".err1"}, err_count1, m_err(t, n1));
        chk({tag, ".fidx1"}, first_err_idx1, m_first(t, n1));
        chk({tag, ".fval1"}, first_err_valid1, m_err(t, n1) != 0);
        chk({tag, ".pass1"}, pass1, graded && (t == exp_tab));
        chk({tag, ".table0"}, table_out0, m_table(t, n0));
        chk({tag, ".err0"}, err_count0, m_err(t, n0));
        chk({tag, ".fidx0"}, first_err_idx0, m_first(t, n0));
        chk({tag, ".fval0"}, first_err_valid0, m_err(t, n0) != 0);
        chk({tag, ".pass0"}, pass0, graded && (t == exp_tab));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".vec1"}, vec_out1, 0);
        chk({tag, ".busy1"}, busy1, 0);
        chk({tag, ".done1"}, done1, 0);
        chk({tag, ".vec0"}, vec_out0, 0);
        chk({tag, ".busy0"}, busy0, 0);
        chk({tag, ".done0"}, done0, 0);
        check_results(tag, 16'h0, 0, 0, 1'b0);
    endtask

    // Full scan; checks the vector walk, busy, done timing, then the final results.
    task automatic run_scan(input string tag, input logic [15:0] t);
        int w1, w0;
        tab = t;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 0; c < 34; c++) begin
            if (c > 0) @(negedge clk);
            w1 = (c / 2 > 15) ? 15 : c / 2;
            w0 = (c > 15) ? 15 : c;
            chk({tag, ".walk1"}, vec_out1, w1);
            chk({tag, ".walk0"}, vec_out0, w0);
            chk({tag, ".busy1"}, busy1, c < 32);
            chk({tag, ".busy0"}, busy0, c < 16);
            chk({tag, ".done1"}, done1, c == 32);
            chk({tag, ".done0"}, done0, c == 16);
        end
        check_results(tag, t, 16, 16, 1'b1);
    endtask

    initial begin
        logic [15:0] r;
        n_vec   = 0;
        n_miss  = 0;
        exp_tab = 16'hF830;
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        tab     = '0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        chk("formula", formula(1'b0), exp_tab);
        run_scan("good", formula(1'b0));
        run_scan("stuck0", 16'h0000);
        run_scan("no_bc", formula(1'b1));
        run_scan("all_wrong", ~exp_tab);
        run_scan("rescan1", formula(1'b0));
        run_scan("rescan2", formula(1'b0));
        for (int i = 0; i < 8; i++) begin
            r = 16'($urandom);
            if (i == 0) r = exp_tab ^ 16'h8000;
            run_scan("rand", r);
        end

        // Abort while the SETTLE=1 instance holds vector 7.
        tab = 16'h0000;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (14) @(negedge clk);
        chk("abort.at7", vec_out1, 7);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        chk("abort.busy1", busy1, 0);
        chk("abort.vec1", vec_out1, 0);
        chk("abort.busy0", busy0, 0);
        chk("abort.vec0", vec_out0, 0);
        check_results("abort", 16'h0000, 7, 14, 1'b0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk("abort.nodone1", done1, 0);
            chk("abort.nodone0", done0, 0);
            chk("abort.idle1", busy1, 0);
        end
        run_scan("after_abort", formula(1'b0));

        // Reset while vector 9 is applied.
        tab = formula(1'b0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (18) @(negedge clk);
        chk("rstmid.at9", vec_out1, 9);
        rst = 1'b1;
        @(negedge clk);
        check_reset("rstmid");
        rst = 1'b0;

        // start together with abort must not leave IDLE.
        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        for (int c = 0; c < 40; c++) begin
            chk("startabort.busy1", busy1, 0);
            chk("startabort.busy0", busy0, 0);
            chk("startabort.done1", done1, 0);
            chk("startabort.vec1", vec_out1, 0);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
Sequencer that exhaustively exercises an N-input single-output combinational block such as the lab's F = A(B + CD) + BC' gate netlists. It drives every input vector in ascending binary order and samples the block's output after a programmable settle time. It builds the observed truth table and compares it against an expected table, giving pass/fail, an error count and the first failing index. It sits beside the combinational block under test: vec_out feeds the block's inputs and f_in receives its output.

Parameters:
N_IN, 4, number of inputs of the block under test; vector bit N_IN-1 is A (MSB), bit 0 is the last input (D for N_IN=4)
SETTLE, 1, extra cycles each vector is held before sampling; 0 is legal; each vector is held SETTLE+1 cycles
EXPECTED, 16'hF830, expected truth table; bit i = required F for vector i; width 2**N_IN

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  begin a scan; honoured only in IDLE or DONE
abort  input  1  return to IDLE at the next edge; overrides start
vec_out  output  N_IN  input vector applied to the block under test
f_in  input  1  output of the block under test
busy  output  1  high in SCAN
done  output  1  one-cycle pulse on entry to DONE
table_out  output  2**N_IN  observed truth table; bit i = f_in sampled for vector i
pass  output  1  valid in DONE; 1 iff table_out == EXPECTED
err_count  output  N_IN+1  number of vectors where the observed value differs from the expected value
first_err_idx  output  N_IN  index of the lowest mismatching vector
first_err_valid  output  1  at least one mismatch was recorded

Behaviour:
- States: IDLE, SCAN, DONE. Encoding is binary.
- Reset values (rst sampled high at an edge): state=IDLE, vec_out=0, busy=0, done=0, table_out=0, pass=0, err_count=0, first_err_idx=0, first_err_valid=0. Reset mid-scan abandons the scan immediately.
- IDLE/DONE with start=1 and abort=0: next state SCAN. vec_out=0, hold counter=0, and table_out, err_count, first_err_* and pass are all cleared in the same edge.
- SCAN:
  - Each vector is held exactly SETTLE+1 cycles.
  - f_in is sampled at the edge that ends the last hold cycle. table_out[vec_out] <= f_in.
  - If f_in != EXPECTED[vec_out]: err_count increments. If first_err_valid=0, first_err_idx<=vec_out and first_err_valid<=1.
  - After sampling, vec_out increments and the hold counter resets. vec_out never exceeds 2**N_IN-1, and the increment never wraps during a scan.
  - On the sample of vector 2**N_IN-1: next state DONE, and vec_out stays at the last vector.
- Latency: start accepted at edge k, done pulses in the cycle after edge k + 2**N_IN*(SETTLE+1).
- DONE:
  - On entry, pass <= (final table == EXPECTED), computed from the table including the last sample.
  - done=1 for the first DONE cycle only.
  - Results and vec_out hold until the next start or rst.
- start during SCAN is ignored.
- abort in any state: next state IDLE, vec_out=0, busy=0, no done pulse. Partial results are kept but pass=0.
- Simultaneous start and abort: abort wins.
- err_count is N_IN+1 bits wide, so a count of 2**N_IN (all wrong) does not overflow.

Decomposition:
- Package scan_pkg holds the state enum (IDLE, SCAN, DONE) and the localparam NUM_VEC = 2**N_IN helper.
- One natural sub-module: hold_timer. It is a SETTLE-cycle down-counter with load and expire outputs and is reused by future multi-output scanners.
- Mismatch and table logic stay in the top module.

Test Plan:
- Correct netlist of F = A(B+CD)+BC', SETTLE=1, pulse start → done 32 cycles later. Required: table_out=16'hF830, pass=1, err_count=0, first_err_valid=0. vec_out steps 0..15, each held 2 cycles.
- f_in stuck at 0 → table_out=0, err_count=7, first_err_idx=4, pass=0.
- F with the BC' term removed (expected table 16'hF800) → err_count=2, first_err_idx=4, first_err_valid=1, pass=0.
- SETTLE=0 with the correct netlist → done 16 cycles after start, pass=1. start re-issued in DONE clears the results and rescans with an identical outcome.
- abort asserted while vec_out=7 → next cycle IDLE, busy=0, vec_out=0, no done pulse. A following start completes normally with pass=1.
- rst asserted mid-scan at vector 9 → all outputs at reset values on the next cycle. start asserted the same cycle as abort → stays IDLE.
